// File: rtl/multiplier_8b_pkg.sv
// Shared widths, stage-1 payload and arithmetic helpers for the pipelined 8x8 multiplier.
// Signed support is compiled in with MULTIPLIER_8B_SIGNED_EN.
package multiplier_8b_pkg;

   localparam int unsigned OPERAND_W = 8;
   localparam int unsigned PRODUCT_W = 16;
   localparam int unsigned PP_W      = 12;
   localparam int unsigned NIBBLE_W  = 4;
   localparam int unsigned LATENCY   = 2;

   // Registered state between the partial-product stage and the summing stage
   typedef struct packed {
      logic            valid;
      logic            neg;
      logic [PP_W-1:0] pp_hi;
      logic [PP_W-1:0] pp_lo;
   } stage1_t;

   // Two's-complement operand to magnitude; -128 maps to 128, which still fits unsigned
   function automatic logic [OPERAND_W-1:0] to_magnitude(input logic [OPERAND_W-1:0] op,
                                                          input logic              signed_mode);
      logic [OPERAND_W-1:0] mag;
      mag = op;
      if (signed_mode && op[OPERAND_W-1]) begin
         mag = OPERAND_W'(~op + 1'b1);
      end
      return mag;
   endfunction

   function automatic logic [PRODUCT_W-1:0] combine(input stage1_t s);
      logic [PRODUCT_W-1:0] sum;
      sum = PRODUCT_W'(s.pp_lo) + (PRODUCT_W'(s.pp_hi) << NIBBLE_W);
      if (s.neg) begin
         sum = PRODUCT_W'(~sum + 1'b1);
      end
      return sum;
   endfunction

endpackage

// File: rtl/multiplier_8b_mult_8x4.sv
// Combinational 8-bit x 4-bit unsigned partial-product generator, 12-bit result.
module mult_8x4
   import multiplier_8b_pkg::*;
(
   input  logic [OPERAND_W-1:0] a,
   input  logic [NIBBLE_W-1:0]  b,
   output logic [PP_W-1:0]      p
);

   logic [PP_W-1:0] acc;

   // Shift-and-add over the four multiplier bits
   always_comb begin
      acc = '0;
      for (int i = 0; i < int'(NIBBLE_W); i++) begin
         if (b[i]) begin
            acc = acc + (PP_W'(a) << i);
         end
      end
   end

   assign p = acc;

endmodule

// File: rtl/multiplier_8b.sv
// Two-stage pipelined 8x8 -> 16 multiplier with valid tagging, no backpressure.
// Define MULTIPLIER_8B_SIGNED_EN to add the is_signed port (two's-complement mode).
module multiplier_8b
   import multiplier_8b_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
`ifdef MULTIPLIER_8B_SIGNED_EN
   input  logic                 is_signed,
`endif
   input  logic                 in_valid,
   input  logic [OPERAND_W-1:0] a,
   input  logic [OPERAND_W-1:0] b,
   output logic                 out_valid,
   output logic [PRODUCT_W-1:0] product
);

   logic                 signed_mode_c;
   logic [OPERAND_W-1:0] mag_a_c;
   logic [OPERAND_W-1:0] mag_b_c;
   logic                 neg_c;
   logic [PP_W-1:0]      pp_lo_c;
   logic [PP_W-1:0]      pp_hi_c;
   stage1_t              s1;

`ifdef MULTIPLIER_8B_SIGNED_EN
   assign signed_mode_c = is_signed;
`else
   assign signed_mode_c = 1'b0;
`endif

   // Multiply magnitudes; the result sign rides along with the partial products
   assign mag_a_c = to_magnitude(a, signed_mode_c);
   assign mag_b_c = to_magnitude(b, signed_mode_c);
   assign neg_c   = signed_mode_c & (a[OPERAND_W-1] ^ b[OPERAND_W-1]);

   mult_8x4 u_pp_lo (
      .a (mag_a_c),
      .b (mag_b_c[NIBBLE_W-1:0]),
      .p (pp_lo_c)
   );

   mult_8x4 u_pp_hi (
      .a (mag_a_c),
      .b (mag_b_c[OPERAND_W-1:NIBBLE_W]),
      .p (pp_hi_c)
   );

   // Stage 1: data loads only with in_valid so idle-cycle operands never enter the pipe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1 <= '0;
      end else begin
         s1.valid <= in_valid;
         if (in_valid) begin
            s1.neg   <= neg_c;
            s1.pp_lo <= pp_lo_c;
            s1.pp_hi <= pp_hi_c;
         end
      end
   end

   // Stage 2: sum partials, apply sign; product holds between valid results
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
         product   <= '0;
      end else begin
         out_valid <= s1.valid;
         if (s1.valid) begin
            product <= combine(s1);
         end
      end
   end

endmodule

// File: tb/tb_multiplier_8b.sv
// Directed self-checking bench for multiplier_8b; covers the signed build when
// MULTIPLIER_8B_SIGNED_EN is defined.
module tb_multiplier_8b;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [7:0]  a;
   logic [7:0]  b;
   logic        out_valid;
   logic [15:0] product;
`ifdef MULTIPLIER_8B_SIGNED_EN
   logic        is_signed;
`endif

   int n_assert;
   int n_fail;

   multiplier_8b dut (
      .clk       (clk),
      .rst       (rst),
`ifdef MULTIPLIER_8B_SIGNED_EN
      .is_signed (is_signed),
`endif
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .product   (product)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Apply one cycle of inputs, then return 1 time unit after the sampling edge
   task automatic cycle(input logic v, input logic [7:0] av, input logic [7:0] bv);
      in_valid = v;
      a        = av;
      b        = bv;
      @(posedge clk);
      #1;
   endtask

`ifdef MULTIPLIER_8B_SIGNED_EN
   task automatic cycle_s(input logic v, input logic s, input logic [7:0] av, input logic [7:0] bv);
      is_signed = s;
      cycle(v, av, bv);
   endtask
`endif

   task automatic idle();
      cycle(1'b0, 8'bx, 8'bx);
   endtask

   task automatic check(input string tag, input logic ev, input logic [15:0] ep);
      n_assert++;
      assert (out_valid === ev && product === ep)
      else begin
         n_fail++;
         $error("FAIL %s: observed out_valid=%0b product=%0d, expected out_valid=%0b product=%0d",
                tag, out_valid, product, ev, ep);
      end
   endtask

   initial begin
      n_assert  = 0;
      n_fail    = 0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      a         = 8'h00;
      b         = 8'h00;
`ifdef MULTIPLIER_8B_SIGNED_EN
      is_signed = 1'b0;
`endif
      #2 rst = 1'b1;
      #1 check("reset_state", 1'b0, 16'd0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;

      // Zero, then single pulse of 199*1
      cycle(1'b1, 8'd0, 8'd0);
      idle();                     check("zero", 1'b1, 16'd0);
      cycle(1'b1, 8'd199, 8'd1);
      idle();                     check("single_199", 1'b1, 16'd199);
      idle();                     check("single_pulse_end", 1'b0, 16'd199);

      // Streaming back-to-back
      cycle(1'b1, 8'd199, 8'd232);
      cycle(1'b1, 8'd17, 8'd232); check("stream_0", 1'b1, 16'd46168);
      idle();                     check("stream_1", 1'b1, 16'd3944);
      idle();                     check("stream_end", 1'b0, 16'd3944);

      // Corners, back-to-back
      cycle(1'b1, 8'd255, 8'd255);
      cycle(1'b1, 8'd255, 8'd0);  check("max", 1'b1, 16'd65025);
      cycle(1'b1, 8'd128, 8'd2);  check("times_zero", 1'b1, 16'd0);
      cycle(1'b1, 8'd1, 8'd16);   check("128x2", 1'b1, 16'd256);
      idle();                     check("hi_nibble_only", 1'b1, 16'd16);
      idle();                     check("corners_end", 1'b0, 16'd16);

      // Bubble pattern 1,0,1
      cycle(1'b1, 8'd3, 8'd5);
      idle();                     check("bubble_a", 1'b1, 16'd15);
      cycle(1'b1, 8'd7, 8'd9);    check("bubble_gap", 1'b0, 16'd15);
      idle();                     check("bubble_b", 1'b1, 16'd63);
      idle();                     check("bubble_end", 1'b0, 16'd63);

      // Asynchronous reset with pairs in flight
      cycle(1'b1, 8'd10, 8'd10);
      cycle(1'b1, 8'd20, 8'd20);  check("pre_reset", 1'b1, 16'd100);
      #2 rst = 1'b1;
      #1 check("async_reset", 1'b0, 16'd0);
      @(posedge clk);
      #1 check("reset_held", 1'b0, 16'd0);
      rst = 1'b0;
      idle();                     check("no_stale_0", 1'b0, 16'd0);
      idle();                     check("no_stale_1", 1'b0, 16'd0);
      cycle(1'b1, 8'd2, 8'd3);
      idle();                     check("post_reset", 1'b1, 16'd6);

`ifdef MULTIPLIER_8B_SIGNED_EN
      cycle_s(1'b1, 1'b1, 8'h80, 8'h80);
      cycle_s(1'b1, 1'b1, 8'hFF, 8'd5);  check("s_m128_m128", 1'b1, 16'd16384);
      cycle_s(1'b1, 1'b0, 8'd255, 8'd5); check("s_m1_5", 1'b1, 16'hFFFB);
      cycle_s(1'b1, 1'b1, 8'd6, 8'hFD);  check("u_255_5", 1'b1, 16'd1275);
      idle();                            check("s_6_m3", 1'b1, 16'hFFEE);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/multiplier_8b.md
Name: multiplier_8b

Overview:
- Pipelined unsigned 8x8 -> 16-bit integer multiplier with valid tagging.
- Sits in datapath arithmetic; accepts one operand pair per clock and returns the full-precision product a fixed 2 cycles later.
- No backpressure; the consumer must accept results when out_valid is high.

Parameters:
- LATENCY, 2, pipeline depth in clocks from input sample to product output. Fixed; documented as a localparam and not overridable.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  a/b hold a valid operand pair this cycle
- a  input  8  multiplicand, unsigned
- b  input  8  multiplier, unsigned
- out_valid  output  1  product holds the result of the pair sampled 2 cycles earlier
- product  output  16  a*b, full precision, registered

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- rst asserted: all pipeline registers clear immediately, without waiting for a clock edge. out_valid=0 and product=16'h0000.
- Reset mid-operation: in-flight pairs are discarded and never produce out_valid. The first valid result follows 2 cycles after the first in_valid sampled after rst deasserts.
- Stage 1, at edge N with in_valid=1: compute and register two partial products.
  - pp_lo = a*b[3:0], 12 bits
  - pp_hi = a*b[7:4], 12 bits
  - v1 <= in_valid
- Stage 2, at edge N+1: if v1, product <= pp_lo + (pp_hi << 4), 16 bits. out_valid <= v1.
- Arithmetic: exact. Max 255*255 = 65025 fits in 16 bits; no overflow or truncation is possible.
- in_valid=0: stage-1 registers may hold or load; product holds its last valid value; out_valid=0 on the following cycle.
- Back-to-back in_valid: throughput is 1 result/cycle, in order, no bubbles.
- X on a/b while in_valid=0 must not propagate to product or out_valid.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: MULTIPLIER_8B_SIGNED_EN
- Defined:
  - Adds input port is_signed (1 bit), sampled with in_valid and pipelined alongside the data.
  - When 1, a, b and product are two's complement.
  - Stage 1 converts operands to magnitude, multiplies unsigned, and registers the result sign (a[7]^b[7]).
  - Stage 2 negates the sum when the sign is 1.
  - -128*-128 = 16384 must be exact.
  - When is_signed=0, behaviour is identical to unsigned mode.
- Undefined: no is_signed port; unsigned only. Latency is 2 in both builds.

Decomposition:
- Package multiplier_8b_pkg:
  - OPERAND_W=8
  - PRODUCT_W=16
  - PP_W=12
  - LATENCY=2
- Sub-module mult_8x4: combinational 8-bit by 4-bit unsigned partial-product generator with a 12-bit result. Instantiated twice in stage 1, once for b[3:0] and once for b[7:4].

Test Plan:
- Reset: assert rst asynchronously mid-cycle with in_valid pairs in flight -> out_valid=0 and product=0 immediately; no stale out_valid after release.
- Zero and single pulses: a=0,b=0 -> product=0. Then a=199,b=1 -> product=199 exactly 2 cycles after sampling, with out_valid=1 for one cycle.
- Streaming: consecutive cycles a=199,b=232 then a=17,b=232 -> product=46168 then 3944 on consecutive cycles, out_valid continuously high.
- Corners: a=255,b=255 -> 65025; a=255,b=0 -> 0; a=128,b=2 -> 256; a=1,b=16 -> 16 (pp_hi path only).
- Bubbles: in_valid pattern 1,0,1 with a=3,b=5 then a=7,b=9 -> out_valid pattern 1,0,1; product 15, holds 15, then 63.
- Signed build (MULTIPLIER_8B_SIGNED_EN):
  - is_signed=1, a=-128, b=-128 -> 16384.
  - is_signed=1, a=-1, b=5 -> 16'hFFFB.
  - is_signed=0, a=255, b=5 -> 1275.
